dm_port_arbiter: RTL

- Shares the single-ported, word-addressed data memory between two requesters: port 0 (CPU MEM stage) and port 1 (debug/DMA loader).
- Arbitrates round-robin, sequences each access as a fixed 3-phase transaction, and routes read data and acknowledgements back to the owner.
- Checks the address range and flags out-of-range accesses without touching memory.
- Sits between the pipeline/bridge and the DM storage array.

---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/dm_port_arbiter_if.sv | 15 +
 rtl/rr_arbiter2.sv | 30 +++
 rtl/dm_port_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic       OWN_M0  = 1'b0;
  localparam logic       OWN_M1  = 1'b1;
  localparam logic [3:0] BE_WORD = 4'hF;

  // True when any address bit above the word-index field is set.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int widx_w);
    return (addr >> (widx_w + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Requester-side command/response bundle for one arbiter port.
interface dm_port_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, ack, err, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, ack, err, rdata);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, on contention the
// port that did not win last time wins.
module rr_arbiter2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       winner
);

  // Pick the winner and drive a one-hot grant when enabled.
  always_comb begin
    winner = OWN_M0;
    gnt    = 2'b00;
    case (req)
      2'b01:   winner = OWN_M0;
      2'b10:   winner = OWN_M1;
      2'b11:   winner = ~last_owner;
      default: winner = OWN_M0;
    endcase
    if (enable && (req != 2'b00)) begin
      gnt = (winner == OWN_M1) ? 2'b10 : 2'b01;
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-ported data memory between two requesters using a
// fixed three-phase IDLE/ISSUE/RESP transaction.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int WIDX_W = 12,
  parameter int DATA_W = 32
)
(
  input  logic                clk,
  input  logic                reset,
  dm_port_arbiter_if.slave    m0,
  dm_port_arbiter_if.slave    m1,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [WIDX_W-1:0]   mem_idx,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t                state;
  state_t                state_nx;
  logic                  last_owner;
  logic                  owner;
  logic                  cap_we;
  logic [DATA_W/8-1:0]   cap_be;
  logic [DATA_W-1:0]     cap_wdata;
  logic [WIDX_W-1:0]     cap_idx;
  logic                  range_err;

  logic [1:0]            gnt;
  logic                  winner;
  logic                  arb_en;
  logic                  sel_we;
  logic [3:0]            sel_be;
  logic [31:0]           sel_addr;
  logic [31:0]           sel_wdata;
  logic [DATA_W-1:0]     resp_data;

  // Grants only in IDLE; masked during reset so every output reads zero.
  assign arb_en = (state == IDLE) && !reset;

  rr_arbiter2 u_arb (
    .req        ({m1.req, m0.req}),
    .last_owner (last_owner),
    .enable     (arb_en),
    .gnt        (gnt),
    .winner     (winner)
  );

  assign m0.gnt = gnt[0];
  assign m1.gnt = gnt[1];

  // Select the winning port's command fields for capture.
  always_comb begin
    sel_we    = m0.we;
    sel_be    = m0.be;
    sel_addr  = m0.addr;
    sel_wdata = m0.wdata;
    if (winner == OWN_M1) begin
      sel_we    = m1.we;
      sel_be    = m1.be;
      sel_addr  = m1.addr;
      sel_wdata = m1.wdata;
    end else begin
      sel_we    = m0.we;
      sel_be    = m0.be;
      sel_addr  = m0.addr;
      sel_wdata = m0.wdata;
    end
  end

  // Next-state logic of the transaction sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (gnt != 2'b00) ? ISSUE : IDLE;
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and command capture on grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWN_M1;
      owner      <= OWN_M0;
      cap_we     <= 1'b0;
      cap_be     <= {(DATA_W/8){1'b0}};
      cap_wdata  <= {DATA_W{1'b0}};
      cap_idx    <= {WIDX_W{1'b0}};
      range_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (gnt != 2'b00) begin
        last_owner <= winner;
        owner      <= winner;
        cap_we     <= sel_we;
        cap_be     <= sel_be;
        cap_wdata  <= sel_wdata;
        cap_idx    <= WIDX_W'(sel_addr >> 2);
        range_err  <= addr_out_of_range(sel_addr, WIDX_W);
      end
    end
  end

  // Memory strobes in ISSUE and the owner's response in RESP.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = {(DATA_W/8){1'b0}};
    mem_idx   = cap_idx;
    mem_wdata = cap_wdata;
    resp_data = {DATA_W{1'b0}};
    m0.ack    = 1'b0;
    m0.err    = 1'b0;
    m0.rdata  = {DATA_W{1'b0}};
    m1.ack    = 1'b0;
    m1.err    = 1'b0;
    m1.rdata  = {DATA_W{1'b0}};
    if (state == ISSUE) begin
      mem_en = !range_err;
      if (cap_we && !range_err) begin
        mem_we = cap_be & BE_WORD;
      end else begin
        mem_we = {(DATA_W/8){1'b0}};
      end
    end else begin
      mem_en = 1'b0;
    end
    if (state == RESP) begin
      if (!cap_we && !range_err) begin
        resp_data = mem_rdata;
      end else begin
        resp_data = {DATA_W{1'b0}};
      end
      if (owner == OWN_M1) begin
        m1.ack   = 1'b1;
        m1.err   = range_err;
        m1.rdata = resp_data;
      end else begin
        m0.ack   = 1'b1;
        m0.err   = range_err;
        m0.rdata = resp_data;
      end
    end else begin
      resp_data = {DATA_W{1'b0}};
    end
  end

endmodule
